pwr_domain_rsp: RTL and testbench
=================================

PWR_DOMAIN_RSP -- requirements
Module: pwr_domain_rsp

Interface
REQ-001 SHALL have parameter SAVE_CYC, default 2, retention-save pulse width in cycles (1..15).
REQ-002 SHALL have parameter RESTORE_CYC, default 2, retention-restore pulse width in cycles (1..15).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 12, maximum cycles to wait for sw_ack (1..15).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port pwr_up, input, 1 bit: target domain state from pwr_ctrl (1 = on).
REQ-007 SHALL have port save, input, 1 bit: retain state on the next power-down.
REQ-008 SHALL have port restore, input, 1 bit: restore state on the next power-up.
REQ-009 SHALL have port iso_up, input, 1 bit: hold isolation while the domain is on.
REQ-010 SHALL have port sw_ack, input, 1 bit: power-switch chain status (1 = rail up).
REQ-011 SHALL have port sw_en, output, 1 bit: power-switch enable.
REQ-012 SHALL have port iso_en, output, 1 bit: isolation clamp enable.
REQ-013 SHALL have port ret_save, output, 1 bit: retention save strobe.
REQ-014 SHALL have port ret_restore, output, 1 bit: retention restore strobe.
REQ-015 SHALL have port clk_en, output, 1 bit: domain clock enable.
REQ-016 SHALL have port pwr_good, output, 1 bit: domain fully on and de-isolated.
REQ-017 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-018 SHALL have port err, output, 1 bit: sticky switch-ack timeout flag.

Function
REQ-019 SHALL implement the FSM states ON, ISO, SAVE, SW_OFF, OFF, SW_ON, RESTORE and DEISO.
REQ-020 SHALL register all outputs and decode them from the state (Moore), valid in the first cycle of each state.
REQ-021 SHALL sample pwr_up, save and restore only in ON and OFF; changes mid-sequence are ignored until the sequence ends.
REQ-022 SHALL move ON to ISO when pwr_up = 0; ISO lasts 1 cycle with iso_en = 1, clk_en = 0 and pwr_good = 0.
REQ-023 SHALL leave ISO for SAVE if save was latched at exit from ON, otherwise for SW_OFF.
REQ-024 SHALL hold ret_save = 1 in SAVE for exactly SAVE_CYC cycles, then enter SW_OFF.
REQ-025 SHALL drive sw_en = 0 in SW_OFF and enter OFF in the cycle after sw_ack = 0 is sampled.
REQ-026 SHALL drive sw_en = 0, iso_en = 1 and clk_en = 0 in OFF, and move to SW_ON when pwr_up = 1.
REQ-027 SHALL drive sw_en = 1 in SW_ON, and on sw_ack = 1 enter RESTORE if restore was latched, otherwise DEISO.
REQ-028 SHALL hold ret_restore = 1 in RESTORE for exactly RESTORE_CYC cycles with clk_en = 0, then enter DEISO.
REQ-029 SHALL spend 1 cycle in DEISO with clk_en = 1 and iso_en = 1, then enter ON.
REQ-030 SHALL drive sw_en = 1, clk_en = 1, iso_en = iso_up (combinationally registered each cycle) and pwr_good = !iso_up in ON.
REQ-031 SHALL never assert ret_save and ret_restore together, and never assert either while sw_en = 0.
REQ-032 SHALL assert busy in every state except ON and OFF.
REQ-033 SHALL use a single 4-bit down-counter for pulse widths and timeouts, loaded on state entry; it must not wrap.

Reset
REQ-034 SHALL, when reset = 0 at a clock edge, enter ON with sw_en = 1, iso_en = 1, clk_en = 0, ret_save = 0, ret_restore = 0, pwr_good = 0, busy = 0 and err = 0.
REQ-035 SHALL, in the first cycle after reset releases, apply the ON decode of REQ-030.
REQ-036 SHALL abort any sequence on a reset asserted mid-operation; no strobe may remain asserted after the reset edge.

Configuration
REQ-037 SHALL, with PWR_RSP_TIMEOUT_EN defined, set err on reaching ACK_TIMEOUT cycles in SW_OFF or SW_ON without the expected sw_ack, then go to OFF (sw_en = 0, iso_en = 1); err is cleared only by reset.
REQ-038 SHALL, without PWR_RSP_TIMEOUT_EN, wait indefinitely in SW_OFF/SW_ON with err tied to 0.

Structure
REQ-039 SHALL place the state enum and the parameter defaults in the shared package pwr_rsp_pkg.
REQ-040 SHALL implement the counter as the sub-module pwr_rsp_cnt (load, decrement, zero flag).

Verification
REQ-041 SHALL cover power-down with save: pwr_up 1->0 at cycle 0, save = 1, SAVE_CYC = 2, sw_ack falls 3 cycles after sw_en -> ISO at 1, ret_save at cycles 2-3, sw_en = 0 at 4, OFF at 8.
REQ-042 SHALL cover power-up with restore: pwr_up 0->1 in OFF, restore = 1, sw_ack rises 2 cycles after sw_en -> ret_restore for 2 cycles, DEISO, then pwr_good = 1 one cycle later.
REQ-043 SHALL cover a mid-sequence pwr_up toggle: pwr_up back to 1 during SAVE -> sequence completes to OFF, then powers up.
REQ-044 SHALL cover timeout with PWR_RSP_TIMEOUT_EN: sw_ack stuck at 0 in SW_ON, ACK_TIMEOUT = 12 -> err = 1 after 12 cycles, state OFF, err held.
REQ-045 SHALL cover reset during SAVE: reset = 0 -> next cycle ret_save = 0, sw_en = 1, busy = 0.
REQ-046 SHALL cover iso_up in ON: iso_up = 1 -> iso_en = 1 and pwr_good = 0 next cycle, and no state change.

Source files
------------

// File: rtl/pwr_rsp_pkg.sv
// Shared types and defaults for the power-domain response sequencer.
// Optional switch-ack timeout is enabled with `define PWR_RSP_TIMEOUT_EN.
package pwr_rsp_pkg;

   localparam int SAVE_CYC_DEF    = 2;
   localparam int RESTORE_CYC_DEF = 2;
   localparam int ACK_TIMEOUT_DEF = 12;

   typedef enum logic [2:0] {
      ST_ON,
      ST_ISO,
      ST_SAVE,
      ST_SW_OFF,
      ST_OFF,
      ST_SW_ON,
      ST_RESTORE,
      ST_DEISO
   } pwr_state_t;

   typedef struct packed {
      logic sw_en;
      logic iso_en;
      logic ret_save;
      logic ret_restore;
      logic clk_en;
      logic pwr_good;
      logic busy;
   } pwr_out_t;

   localparam pwr_out_t RESET_OUT = '{sw_en: 1'b1, iso_en: 1'b1, ret_save: 1'b0,
                                      ret_restore: 1'b0, clk_en: 1'b0,
                                      pwr_good: 1'b0, busy: 1'b0};

   // Moore decode; iso_up only matters while the domain is fully on.
   function automatic pwr_out_t decode_out(input pwr_state_t st, input logic iso_up);
      pwr_out_t o;
      o = '{sw_en: 1'b1, iso_en: 1'b1, ret_save: 1'b0, ret_restore: 1'b0,
            clk_en: 1'b0, pwr_good: 1'b0, busy: 1'b1};
      case (st)
         ST_ON: begin
            o.iso_en   = iso_up;
            o.clk_en   = 1'b1;
            o.pwr_good = !iso_up;
            o.busy     = 1'b0;
         end
         ST_SAVE:    o.ret_save = 1'b1;
         ST_SW_OFF:  o.sw_en = 1'b0;
         ST_OFF: begin
            o.sw_en = 1'b0;
            o.busy  = 1'b0;
         end
         ST_RESTORE: o.ret_restore = 1'b1;
         ST_DEISO:   o.clk_en = 1'b1;
         default:    ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/pwr_rsp_cnt.sv
// 4-bit loadable down-counter that saturates at zero.
module pwr_rsp_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_reg <= 4'd0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != 4'd0)) begin
         cnt_reg <= cnt_reg - 4'd1;
      end
   end

   assign zero = (cnt_reg == 4'd0);

endmodule

// File: rtl/pwr_domain_rsp.sv
// Power-domain response sequencer: isolation, retention, switch handshake.
// Build with `define PWR_RSP_TIMEOUT_EN to enable the sticky ack-timeout error.
module pwr_domain_rsp
   import pwr_rsp_pkg::*;
#(
   parameter int SAVE_CYC    = SAVE_CYC_DEF,
   parameter int RESTORE_CYC = RESTORE_CYC_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic pwr_up,
   input  logic save,
   input  logic restore,
   input  logic iso_up,
   input  logic sw_ack,
   output logic sw_en,
   output logic iso_en,
   output logic ret_save,
   output logic ret_restore,
   output logic clk_en,
   output logic pwr_good,
   output logic busy,
   output logic err
);

   localparam logic [3:0] SAVE_LD    = 4'(SAVE_CYC - 1);
   localparam logic [3:0] RESTORE_LD = 4'(RESTORE_CYC - 1);
   localparam logic [3:0] ACK_LD     = 4'(ACK_TIMEOUT - 1);

   pwr_state_t state_reg, state_next;
   pwr_out_t   out_reg;
   logic       save_lat_reg, save_lat_next;
   logic       restore_lat_reg, restore_lat_next;
   logic       err_reg, err_next;
   logic       cnt_load, cnt_dec, cnt_zero;
   logic [3:0] cnt_load_val;

   pwr_rsp_cnt u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_next       = state_reg;
      save_lat_next    = save_lat_reg;
      restore_lat_next = restore_lat_reg;
      err_next         = err_reg;
      case (state_reg)
         ST_ON: begin
            if (!pwr_up) begin
               state_next    = ST_ISO;
               save_lat_next = save;
            end
         end
         ST_ISO:  state_next = save_lat_reg ? ST_SAVE : ST_SW_OFF;
         ST_SAVE: begin
            if (cnt_zero) state_next = ST_SW_OFF;
         end
         ST_SW_OFF: begin
            if (!sw_ack) begin
               state_next = ST_OFF;
            end
`ifdef PWR_RSP_TIMEOUT_EN
            else if (cnt_zero) begin
               state_next = ST_OFF;
               err_next   = 1'b1;
            end
`endif
         end
         ST_OFF: begin
            if (pwr_up) begin
               state_next       = ST_SW_ON;
               restore_lat_next = restore;
            end
         end
         ST_SW_ON: begin
            if (sw_ack) begin
               state_next = restore_lat_reg ? ST_RESTORE : ST_DEISO;
            end
`ifdef PWR_RSP_TIMEOUT_EN
            else if (cnt_zero) begin
               state_next = ST_OFF;
               err_next   = 1'b1;
            end
`endif
         end
         ST_RESTORE: begin
            if (cnt_zero) state_next = ST_DEISO;
         end
         ST_DEISO: state_next = ST_ON;
         default:  state_next = ST_ON;
      endcase
   end

   // Counter is reloaded on every state entry so each timed state starts fresh.
   always_comb begin
      cnt_load     = (state_next != state_reg);
      cnt_load_val = 4'd0;
      case (state_next)
         ST_SAVE:             cnt_load_val = SAVE_LD;
         ST_RESTORE:          cnt_load_val = RESTORE_LD;
         ST_SW_OFF, ST_SW_ON: cnt_load_val = ACK_LD;
         default:             cnt_load_val = 4'd0;
      endcase
      cnt_dec = (state_reg == ST_SAVE) || (state_reg == ST_RESTORE) ||
                (state_reg == ST_SW_OFF) || (state_reg == ST_SW_ON);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= ST_ON;
         out_reg         <= RESET_OUT;
         save_lat_reg    <= 1'b0;
         restore_lat_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         out_reg         <= decode_out(state_next, iso_up);
         save_lat_reg    <= save_lat_next;
         restore_lat_reg <= restore_lat_next;
         err_reg         <= err_next;
      end
   end

   assign sw_en       = out_reg.sw_en;
   assign iso_en      = out_reg.iso_en;
   assign ret_save    = out_reg.ret_save;
   assign ret_restore = out_reg.ret_restore;
   assign clk_en      = out_reg.clk_en;
   assign pwr_good    = out_reg.pwr_good;
   assign busy        = out_reg.busy;
   assign err         = err_reg;

endmodule

// File: tb/tb_pwr_domain_rsp.sv
// Directed bench for pwr_domain_rsp; outputs compared as one packed vector
// {sw_en, iso_en, ret_save, ret_restore, clk_en, pwr_good, busy, err}.
module tb_pwr_domain_rsp;

   logic clk = 1'b0;
   logic reset, pwr_up, save, restore, iso_up, sw_ack;
   logic sw_en, iso_en, ret_save, ret_restore, clk_en, pwr_good, busy, err;

   int errors = 0;
   int checks = 0;

   localparam logic [7:0] O_RST     = 8'b1100_0000;
   localparam logic [7:0] O_ON      = 8'b1000_1100;
   localparam logic [7:0] O_ON_ISO  = 8'b1100_1000;
   localparam logic [7:0] O_ISO     = 8'b1100_0010;
   localparam logic [7:0] O_SAVE    = 8'b1110_0010;
   localparam logic [7:0] O_SW_OFF  = 8'b0100_0010;
   localparam logic [7:0] O_OFF     = 8'b0100_0000;
   localparam logic [7:0] O_SW_ON   = 8'b1100_0010;
   localparam logic [7:0] O_RESTORE = 8'b1101_0010;
   localparam logic [7:0] O_DEISO   = 8'b1100_1010;
   localparam logic [7:0] O_OFF_ERR = 8'b0100_0001;

   always #5 clk = ~clk;

   pwr_domain_rsp dut (
      .clk         (clk),
      .reset       (reset),
      .pwr_up      (pwr_up),
      .save        (save),
      .restore     (restore),
      .iso_up      (iso_up),
      .sw_ack      (sw_ack),
      .sw_en       (sw_en),
      .iso_en      (iso_en),
      .ret_save    (ret_save),
      .ret_restore (ret_restore),
      .clk_en      (clk_en),
      .pwr_good    (pwr_good),
      .busy        (busy),
      .err         (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
      checks++;
      if (obs !== exp_val) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp_val);
      end else begin
         $display("ok   %s: %b", tag, obs);
      end
   endtask

   function automatic logic [7:0] outs();
      return {sw_en, iso_en, ret_save, ret_restore, clk_en, pwr_good, busy, err};
   endfunction

   initial begin
      reset = 1'b0; pwr_up = 1'b1; save = 1'b0; restore = 1'b0;
      iso_up = 1'b0; sw_ack = 1'b1;
      tick(); tick();
      check("reset_state", outs(), O_RST);

      reset = 1'b1;
      tick();
      check("on_after_reset", outs(), O_ON);

      // iso_up held in ON
      iso_up = 1'b1;
      tick();
      check("on_iso_up", outs(), O_ON_ISO);
      tick();
      check("on_iso_up_hold", outs(), O_ON_ISO);
      iso_up = 1'b0;
      tick();
      check("on_iso_clear", outs(), O_ON);

      // power-down with save: cycle 0 = pwr_up falls
      pwr_up = 1'b0; save = 1'b1;
      tick(); save = 1'b0;
      check("dn_c1_iso", outs(), O_ISO);
      tick(); check("dn_c2_save", outs(), O_SAVE);
      tick(); check("dn_c3_save", outs(), O_SAVE);
      tick(); check("dn_c4_swoff", outs(), O_SW_OFF);
      tick(); check("dn_c5_swoff", outs(), O_SW_OFF);
      tick(); check("dn_c6_swoff", outs(), O_SW_OFF);
      tick(); check("dn_c7_swoff", outs(), O_SW_OFF);
      sw_ack = 1'b0;
      tick(); check("dn_c8_off", outs(), O_OFF);
      tick(); check("dn_off_hold", outs(), O_OFF);

      // power-up with restore, ack 2 cycles after sw_en
      pwr_up = 1'b1; restore = 1'b1;
      tick(); restore = 1'b0;
      check("up_swon1", outs(), O_SW_ON);
      tick(); check("up_swon2", outs(), O_SW_ON);
      sw_ack = 1'b1;
      tick(); check("up_restore1", outs(), O_RESTORE);
      tick(); check("up_restore2", outs(), O_RESTORE);
      tick(); check("up_deiso", outs(), O_DEISO);
      tick(); check("up_on_good", outs(), O_ON);

      // pwr_up bounces back high during SAVE: sequence still finishes to OFF
      pwr_up = 1'b0; save = 1'b1;
      tick(); save = 1'b0;
      check("tog_iso", outs(), O_ISO);
      tick(); check("tog_save1", outs(), O_SAVE);
      pwr_up = 1'b1;
      tick(); check("tog_save2", outs(), O_SAVE);
      tick(); check("tog_swoff", outs(), O_SW_OFF);
      sw_ack = 1'b0;
      tick(); check("tog_off", outs(), O_OFF);
      tick(); check("tog_swon", outs(), O_SW_ON);
      sw_ack = 1'b1;
      tick(); check("tog_deiso", outs(), O_DEISO);
      tick(); check("tog_on", outs(), O_ON);

      // switch ack stuck low while powering up
      pwr_up = 1'b0;
      tick(); check("to_iso", outs(), O_ISO);
      tick(); check("to_swoff", outs(), O_SW_OFF);
      sw_ack = 1'b0;
      tick(); check("to_off", outs(), O_OFF);
      pwr_up = 1'b1;
      tick(); check("to_swon_c1", outs(), O_SW_ON);
      pwr_up = 1'b0;
      for (int i = 2; i <= 12; i++) begin
         tick();
         check($sformatf("to_swon_c%0d", i), outs(), O_SW_ON);
      end
      tick();
`ifdef PWR_RSP_TIMEOUT_EN
      check("to_expired_off", outs(), O_OFF_ERR);
      tick(); tick();
      check("to_err_held", outs(), O_OFF_ERR);
`else
      check("to_still_waiting", outs(), O_SW_ON);
      tick(); tick();
      check("to_no_err", outs(), O_SW_ON);
      sw_ack = 1'b1;
      tick(); check("to_late_ack_deiso", outs(), O_DEISO);
`endif

      // reset in the middle of SAVE
      reset = 1'b0; pwr_up = 1'b1; sw_ack = 1'b1;
      tick(); reset = 1'b1;
      tick(); check("rs_on", outs(), O_ON);
      pwr_up = 1'b0; save = 1'b1;
      tick(); save = 1'b0;
      check("rs_iso", outs(), O_ISO);
      tick(); check("rs_save", outs(), O_SAVE);
      reset = 1'b0;
      tick(); check("rs_abort", outs(), O_RST);
      reset = 1'b1; pwr_up = 1'b1;
      tick(); check("rs_recover_on", outs(), O_ON);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
